// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_WORD_W     = 9;
  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    WAIT_IDLE = 2'd1,
    RUN       = 2'd2
  } rx_ctrl_state_e;

  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  // Bit 8 of the word is the parity bit, so XOR over all nine bits is 0 on a good word.
  function automatic logic parity_err(input logic [UART_WORD_W-1:0] word,
                                      input logic                   check_en,
                                      input logic                   odd);
    return check_en & ((^word) ^ odd);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fallthrough FIFO; head entry is visible on rdata_o whenever not empty.
module uart_rx_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [8:0],
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output entry_t        rdata_o,
  output logic [AW:0]   level_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;

  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer around the 9-bit UART receiver core: baud tick, pin sync, idle/break
// gating and a word FIFO presented as a valid/ready stream.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int  CLK_DIV     = 27,
  parameter int  FIFO_DEPTH  = 4,
  parameter bit  PARITY_EN   = 1'b1,
  parameter bit  PARITY_ODD  = 1'b0,
  parameter int  BREAK_TICKS = 160,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   en_i,
  input  logic                   rx_pin_i,
  output logic                   core_rx_o,
  output logic                   b_tick_o,
  input  logic                   core_done_i,
  input  logic [UART_WORD_W-1:0] core_dout_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [UART_DATA_W-1:0] m_data_o,
  output logic                   m_perr_o,
  output logic                   overrun_o,
  input  logic                   clr_overrun_i,
  output logic                   break_det_o,
  output logic [LVL_W-1:0]       fifo_level_o
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDLE_W = $clog2(UART_OVERSAMPLE);
  localparam int LOW_W  = $clog2(BREAK_TICKS + 1);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(UART_OVERSAMPLE - 1);
  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(BREAK_TICKS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              b_tick_q, b_tick_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  rx_ctrl_state_e    state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [LOW_W-1:0]  low_q, low_d;
  logic              brk_q, brk_d;
  logic              overrun_q, overrun_d;
  logic              capture_en;
  logic              push, pop, full, empty;
  rx_entry_t         wentry, rentry;

  // b_tick is registered but asserted while the count sits at CLK_DIV-1.
  always_comb begin
    cnt_d    = '0;
    b_tick_d = 1'b0;
    if (en_i) begin
      cnt_d    = (cnt_q == BAUD_LAST) ? '0 : cnt_q + 1'b1;
      b_tick_d = (cnt_d == BAUD_LAST);
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q     <= '0;
      b_tick_q  <= 1'b0;
      sync_q    <= 2'b11;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      b_tick_q  <= b_tick_d;
      sync_q    <= {sync_q[0], rx_pin_i};
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= DISABLED;
      idle_q  <= '0;
      low_q   <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      low_q   <= low_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    low_d   = low_q;
    brk_d   = 1'b0;
    if (!en_i) begin
      state_d = DISABLED;
      idle_d  = '0;
      low_d   = '0;
    end else begin
      unique case (state_q)
        DISABLED: begin
          state_d = WAIT_IDLE;
          idle_d  = '0;
        end
        WAIT_IDLE: if (b_tick_q) begin
          if (!rx_s) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            state_d = RUN;
            idle_d  = '0;
            low_d   = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        RUN: if (b_tick_q) begin
          if (rx_s) begin
            low_d = '0;
          end else if (low_q == LOW_LAST) begin
            state_d = WAIT_IDLE;
            low_d   = '0;
            idle_d  = '0;
            brk_d   = 1'b1;
          end else begin
            low_d = low_q + 1'b1;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  // Outside RUN the core sees an idle line so it falls back to waiting for a start bit.
  always_comb begin
    core_rx_o  = 1'b1;
    capture_en = 1'b0;
    if (state_q == RUN) begin
      core_rx_o  = rx_s;
      capture_en = 1'b1;
    end
  end

  assign push        = core_done_i & capture_en;
  assign pop         = m_ready_i & ~empty;
  assign wentry.perr = parity_err(core_dout_i, PARITY_EN, PARITY_ODD);
  assign wentry.data = core_dout_i[UART_DATA_W-1:0];

  always_comb begin
    overrun_d = overrun_q;
    if (push & full & ~pop) overrun_d = 1'b1;
    else if (clr_overrun_i) overrun_d = 1'b0;
  end

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rx_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (resetn_i),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .rdata_o (rentry),
    .level_o (fifo_level_o)
  );

  assign m_valid_o   = ~empty;
  assign m_data_o    = rentry.data;
  assign m_perr_o    = rentry.perr;
  assign overrun_o   = overrun_q;
  assign b_tick_o    = b_tick_q;
  assign break_det_o = brk_q;

endmodule
